dut_driver: RTL and testbench



---
 rtl/dut_driver_if.sv | 36 +++
 rtl/dut_driver.sv | 137 +++++++++++++
 tb/tb_dut_driver.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dut_driver_if.sv
// FIFO and DUT-facing signal bundle for dut_driver.
// master = the driver engine, slave = the FIFOs/DUT side.
interface dut_driver_if #(
  parameter int STF_WIDTH = 24,
  parameter int RTF_WIDTH = 24,
  parameter int CMD_WIDTH = 5,
  parameter int REQ_WIDTH = 3,
  parameter int DIF_WIDTH = REQ_WIDTH + CMD_WIDTH + STF_WIDTH
);
  logic                 dififo_rdreq;
  logic                 dififo_rdempty;
  logic [DIF_WIDTH-1:0] dififo_dataq;
  logic                 sfifo_rdreq;
  logic                 sfifo_rdempty;
  logic [STF_WIDTH-1:0] sfifo_dataq;
  logic [RTF_WIDTH-1:0] rfifo_data;
  logic                 rfifo_wrreq;
  logic                 rfifo_wrfull;
  logic [STF_WIDTH-1:0] dut_in;
  logic [RTF_WIDTH-1:0] dut_out;
  logic                 dut_reset;

  modport master (
    output dififo_rdreq, input dififo_rdempty, dififo_dataq,
    output sfifo_rdreq, input sfifo_rdempty, sfifo_dataq,
    output rfifo_data, rfifo_wrreq, input rfifo_wrfull,
    output dut_in, dut_reset, input dut_out
  );

  modport slave (
    input dififo_rdreq, output dififo_rdempty, dififo_dataq,
    input sfifo_rdreq, output sfifo_rdempty, sfifo_dataq,
    input rfifo_data, rfifo_wrreq, output rfifo_wrfull,
    input dut_in, dut_reset, output dut_out
  );
endinterface

// File: rtl/dut_driver.sv
// Target-side FIFO protocol engine: pops requests/stimulus, drives the DUT,
// samples its masked response and pushes results.
module dut_driver #(
  parameter int STF_WIDTH = 24,
  parameter int RTF_WIDTH = 24,
  parameter int CMD_WIDTH = 5,
  parameter int REQ_WIDTH = 3,
  parameter int DIF_WIDTH = REQ_WIDTH + CMD_WIDTH + STF_WIDTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        busy,
  output logic        err_req,
  output logic [15:0] vec_count,
  dut_driver_if.master bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_DI_REQ   = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_ST_REQ   = 4'd3;
  localparam logic [3:0] S_ST_LATCH = 4'd4;
  localparam logic [3:0] S_SETTLE   = 4'd5;
  localparam logic [3:0] S_CAPTURE  = 4'd6;
  localparam logic [3:0] S_PUSH     = 4'd7;
  localparam logic [3:0] S_WAIT     = 4'd8;
  localparam logic [3:0] S_DUTRST   = 4'd9;

  localparam logic [REQ_WIDTH-1:0] OP_NOP    = REQ_WIDTH'(0);
  localparam logic [REQ_WIDTH-1:0] OP_VECTOR = REQ_WIDTH'(1);
  localparam logic [REQ_WIDTH-1:0] OP_WAIT   = REQ_WIDTH'(2);
  localparam logic [REQ_WIDTH-1:0] OP_MASK   = REQ_WIDTH'(3);
  localparam logic [REQ_WIDTH-1:0] OP_DUTRST = REQ_WIDTH'(4);

  logic [3:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [RTF_WIDTH-1:0] mask_q, mask_d;
  logic [RTF_WIDTH-1:0] result_q, result_d;
  logic [STF_WIDTH-1:0] din_q, din_d;
  logic [15:0]          vcnt_q, vcnt_d;
  logic                 err_q, err_d;

  logic [REQ_WIDTH-1:0] op;
  logic [CMD_WIDTH-1:0] cmd;
  logic [STF_WIDTH-1:0] arg;

  // The request word is only meaningful during DECODE (one cycle after the pop).
  assign {op, cmd, arg} = bus.dififo_dataq;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    result_d = result_q;
    din_d    = din_q;
    vcnt_d   = vcnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE:   if (enable && !bus.dififo_rdempty) state_d = S_DI_REQ;
      S_DI_REQ: state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_IDLE;
        case (op)
          OP_NOP:    begin end
          OP_VECTOR: begin cnt_d = 16'(cmd); state_d = S_ST_REQ; end
          OP_WAIT: begin
            cnt_d = arg[15:0];
            if (arg[15:0] != 16'd0) state_d = S_WAIT;
          end
          OP_MASK:   mask_d = arg[RTF_WIDTH-1:0];
          OP_DUTRST: begin cnt_d = 16'(cmd); state_d = S_DUTRST; end
          default:   err_d = 1'b1;
        endcase
      end
      S_ST_REQ: if (!bus.sfifo_rdempty) state_d = S_ST_LATCH;
      S_ST_LATCH: begin
        din_d   = bus.sfifo_dataq;
        state_d = (cnt_q == 16'd0) ? S_CAPTURE : S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        result_d = bus.dut_out & mask_q;
        state_d  = S_PUSH;
      end
      S_PUSH: if (!bus.rfifo_wrfull) begin
        vcnt_d  = vcnt_q + 16'd1;
        state_d = S_IDLE;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = S_IDLE;
      end
      // Counts cmd down to 0 inclusive, so reset is held cmd+1 cycles.
      S_DUTRST: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mask_q   <= '1;
      result_q <= '0;
      din_q    <= '0;
      vcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      din_q    <= din_d;
      vcnt_q   <= vcnt_d;
      err_q    <= err_d;
    end
  end

  // Strobes gate on the FIFO flags so a stall simply retries next cycle.
  assign bus.dififo_rdreq = (state_q == S_DI_REQ);
  assign bus.sfifo_rdreq  = (state_q == S_ST_REQ) && !bus.sfifo_rdempty;
  assign bus.rfifo_wrreq  = (state_q == S_PUSH) && !bus.rfifo_wrfull;
  assign bus.rfifo_data   = result_q;
  assign bus.dut_in       = din_q;
  assign bus.dut_reset    = (state_q == S_DUTRST);
  assign busy             = (state_q != S_IDLE);
  assign err_req          = err_q;
  assign vec_count        = vcnt_q;

endmodule

// File: tb/tb_dut_driver.sv
// Directed bench for dut_driver: hand-fed FIFO flags, dut_out looped from dut_in.
module tb_dut_driver;
  localparam int STF = 24, RTF = 24, CMDW = 5, REQW = 3, DIFW = 32;

  logic        clock = 1'b0;
  logic        reset, enable;
  logic        busy, err_req;
  logic [15:0] vec_count;
  int          n_vec = 0, n_bad = 0;

  dut_driver_if #(.STF_WIDTH(STF), .RTF_WIDTH(RTF), .CMD_WIDTH(CMDW), .REQ_WIDTH(REQW)) bus ();

  dut_driver #(.STF_WIDTH(STF), .RTF_WIDTH(RTF), .CMD_WIDTH(CMDW), .REQ_WIDTH(REQW)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .busy(busy),
    .err_req(err_req), .vec_count(vec_count), .bus(bus.master)
  );

  assign bus.dut_out = bus.dut_in[RTF-1:0];

  always #5 clock = ~clock;

  // Negedge monitor: cycle index and event counters read by the tests.
  int cyc = 0, n_dirq = 0, n_sfrq = 0, n_wr = 0, n_drst = 0, n_busy = 0, n_viol = 0;
  int di_cyc = 0, di_gap = 0, wr_cyc = 0, chg_cyc = 0;
  logic [RTF-1:0] wr_data = '0;
  logic [STF-1:0] prev_in = '0;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (bus.dififo_rdreq) begin n_dirq <= n_dirq + 1; di_gap <= cyc - di_cyc; di_cyc <= cyc; end
    if (bus.sfifo_rdreq) n_sfrq <= n_sfrq + 1;
    if ((bus.sfifo_rdreq && bus.sfifo_rdempty) || (bus.dififo_rdreq && bus.dififo_rdempty)
        || (bus.rfifo_wrreq && bus.rfifo_wrfull)) n_viol <= n_viol + 1;
    if (bus.rfifo_wrreq) begin n_wr <= n_wr + 1; wr_data <= bus.rfifo_data; wr_cyc <= cyc; end
    if (bus.dut_reset) n_drst <= n_drst + 1;
    if (busy) n_busy <= n_busy + 1;
    prev_in <= bus.dut_in;
    if (bus.dut_in !== prev_in) chg_cyc <= cyc;
  end

  function automatic logic [DIFW-1:0] mk(input logic [2:0] op, input logic [4:0] c, input logic [23:0] d);
    return {op, c, d};
  endfunction

  task automatic at_pos(); @(posedge clock); #1; endtask
  task automatic at_neg(); @(negedge clock); #1; endtask

  // Offers one request word; returns during DECODE with the request FIFO empty again.
  task automatic issue(input logic [DIFW-1:0] w);
    int base, k;
    base = n_dirq; k = 0;
    at_pos();
    bus.dififo_dataq = w; bus.dififo_rdempty = 1'b0;
    while (n_dirq == base && k < 20) begin at_neg(); k++; end
    n_vec++;
    if (n_dirq - base !== 1) begin n_bad++; $display("FAIL issue_pop: pops %0d want 1", n_dirq - base); end
    at_pos();
    bus.dififo_rdempty = 1'b1;
  endtask

  task automatic wait_wr(input int base);
    int k;
    k = 0;
    while (n_wr == base && k < 100) begin at_neg(); k++; end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    at_neg();
    while (busy && k < 100) begin at_neg(); k++; end
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_timeout: busy %b want 0", busy); end
  endtask

  task automatic test_reset();
    logic [5:0] strobes;
    reset = 1'b1; enable = 1'b0;
    bus.dififo_rdempty = 1'b1; bus.dififo_dataq = '0;
    bus.sfifo_rdempty = 1'b1; bus.sfifo_dataq = '0; bus.rfifo_wrfull = 1'b0;
    repeat (3) at_neg();
    strobes = {busy, err_req, bus.dififo_rdreq, bus.sfifo_rdreq, bus.rfifo_wrreq, bus.dut_reset};
    n_vec++; if (strobes !== 6'b0) begin n_bad++; $display("FAIL reset_strobes: got %b want 000000", strobes); end
    n_vec++; if (bus.dut_in !== 24'h0) begin n_bad++; $display("FAIL reset_dut_in: got %h want 000000", bus.dut_in); end
    n_vec++; if (bus.rfifo_data !== 24'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 000000", bus.rfifo_data); end
    n_vec++; if (vec_count !== 16'h0) begin n_bad++; $display("FAIL reset_vcnt: got %0d want 0", vec_count); end
    at_pos();
    reset = 1'b0; enable = 1'b1;
  endtask

  task automatic test_vector();
    int bw, bs;
    bw = n_wr; bs = n_sfrq;
    bus.sfifo_dataq = 24'hA5A5A5; bus.sfifo_rdempty = 1'b0;
    issue(mk(3'd1, 5'd0, 24'h0));
    wait_wr(bw);
    n_vec++; if (wr_data !== 24'hA5A5A5) begin n_bad++; $display("FAIL vec_data: got %h want a5a5a5", wr_data); end
    n_vec++; if (wr_cyc - di_cyc !== 5) begin n_bad++; $display("FAIL vec_latency: got %0d want 5", wr_cyc - di_cyc); end
    n_vec++; if (wr_cyc - chg_cyc !== 1) begin n_bad++; $display("FAIL vec_settle: got %0d want 1", wr_cyc - chg_cyc); end
    n_vec++; if (n_sfrq - bs !== 1) begin n_bad++; $display("FAIL vec_spop: got %0d want 1", n_sfrq - bs); end
    at_neg();
    n_vec++; if (vec_count !== 16'd1) begin n_bad++; $display("FAIL vec_count: got %0d want 1", vec_count); end
    at_pos(); bus.sfifo_rdempty = 1'b1;
    wait_idle();
  endtask

  task automatic test_mask();
    int bw;
    issue(mk(3'd3, 5'd0, 24'h0000FF));
    wait_idle();
    bw = n_wr;
    bus.sfifo_dataq = 24'h123456; bus.sfifo_rdempty = 1'b0;
    issue(mk(3'd1, 5'd3, 24'h0));
    wait_wr(bw);
    n_vec++; if (wr_data !== 24'h000056) begin n_bad++; $display("FAIL mask_data: got %h want 000056", wr_data); end
    n_vec++; if (wr_cyc - di_cyc !== 8) begin n_bad++; $display("FAIL mask_latency: got %0d want 8", wr_cyc - di_cyc); end
    n_vec++; if (wr_cyc - chg_cyc !== 4) begin n_bad++; $display("FAIL mask_settle: got %0d want 4", wr_cyc - chg_cyc); end
    at_pos(); bus.sfifo_rdempty = 1'b1;
    wait_idle();
    n_vec++; if (vec_count !== 16'd2) begin n_bad++; $display("FAIL mask_vcnt: got %0d want 2", vec_count); end
  endtask

  task automatic test_sfifo_empty();
    int bw, bs;
    bw = n_wr; bs = n_sfrq;
    bus.sfifo_dataq = 24'h00C3C3; bus.sfifo_rdempty = 1'b1;
    issue(mk(3'd1, 5'd1, 24'h0));
    repeat (10) at_neg();
    n_vec++; if (n_sfrq - bs !== 0) begin n_bad++; $display("FAIL empty_nopop: got %0d want 0", n_sfrq - bs); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL empty_busy: got %b want 1", busy); end
    at_pos(); bus.sfifo_rdempty = 1'b0;
    wait_wr(bw);
    at_pos(); bus.sfifo_rdempty = 1'b1;
    n_vec++; if (n_sfrq - bs !== 1) begin n_bad++; $display("FAIL empty_onepop: got %0d want 1", n_sfrq - bs); end
    n_vec++; if (wr_data !== 24'h0000C3) begin n_bad++; $display("FAIL empty_data: got %h want 0000c3", wr_data); end
    repeat (5) at_neg();
    n_vec++; if (n_wr - bw !== 1) begin n_bad++; $display("FAIL empty_onepush: got %0d want 1", n_wr - bw); end
    n_vec++; if (n_viol !== 0) begin n_bad++; $display("FAIL fifo_protocol: got %0d violations want 0", n_viol); end
    wait_idle();
  endtask

  task automatic test_wrfull();
    int bw, k;
    issue(mk(3'd3, 5'd0, 24'hFFFFFF));
    wait_idle();
    bw = n_wr; k = 0;
    bus.sfifo_dataq = 24'h5A0F33; bus.sfifo_rdempty = 1'b0; bus.rfifo_wrfull = 1'b1;
    issue(mk(3'd1, 5'd0, 24'h0));
    while ((cyc - 1) < di_cyc + 11 && k < 50) begin
      at_neg(); k++;
      if ((cyc - 1) >= di_cyc + 5) begin
        n_vec++;
        if (n_wr != bw || bus.rfifo_wrreq !== 1'b0 || bus.rfifo_data !== 24'h5A0F33) begin
          n_bad++; $display("FAIL stall_hold: wrreq %b data %h want 0 5a0f33", bus.rfifo_wrreq, bus.rfifo_data);
        end
      end
    end
    at_pos(); bus.rfifo_wrfull = 1'b0;
    wait_wr(bw);
    n_vec++; if (wr_cyc - di_cyc !== 12) begin n_bad++; $display("FAIL stall_release: got %0d want 12", wr_cyc - di_cyc); end
    n_vec++; if (wr_data !== 24'h5A0F33) begin n_bad++; $display("FAIL stall_data: got %h want 5a0f33", wr_data); end
    at_pos(); bus.sfifo_rdempty = 1'b1;
    wait_idle();
    n_vec++; if (n_wr - bw !== 1) begin n_bad++; $display("FAIL stall_onepush: got %0d want 1", n_wr - bw); end
  endtask

  task automatic test_dutrst_wait_err();
    int bd, bb;
    bd = n_drst; bb = n_busy;
    issue(mk(3'd4, 5'd2, 24'h0));
    wait_idle();
    n_vec++; if (n_drst - bd !== 3) begin n_bad++; $display("FAIL dutrst_len: got %0d want 3", n_drst - bd); end
    n_vec++; if (n_busy - bb !== 5) begin n_bad++; $display("FAIL dutrst_busy: got %0d want 5", n_busy - bb); end
    n_vec++; if (bus.dut_in !== 24'h5A0F33) begin n_bad++; $display("FAIL dutrst_hold_in: got %h want 5a0f33", bus.dut_in); end
    bb = n_busy;
    issue(mk(3'd2, 5'd0, 24'd5));
    wait_idle();
    n_vec++; if (n_busy - bb !== 7) begin n_bad++; $display("FAIL wait5_busy: got %0d want 7", n_busy - bb); end
    bb = n_busy;
    issue(mk(3'd2, 5'd0, 24'd0));
    wait_idle();
    n_vec++; if (n_busy - bb !== 2) begin n_bad++; $display("FAIL wait0_busy: got %0d want 2", n_busy - bb); end
    n_vec++; if (err_req !== 1'b0) begin n_bad++; $display("FAIL err_clean: got %b want 0", err_req); end
    issue(mk(3'd6, 5'd0, 24'h0));
    wait_idle();
    n_vec++; if (err_req !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err_req); end
    bb = n_busy;
    issue(mk(3'd0, 5'd0, 24'h0));
    wait_idle();
    n_vec++; if (err_req !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err_req); end
    n_vec++; if (n_busy - bb !== 2) begin n_bad++; $display("FAIL nop_busy: got %0d want 2", n_busy - bb); end
  endtask

  task automatic test_back_to_back();
    int b, k;
    b = n_dirq; k = 0;
    at_pos();
    bus.dififo_dataq = mk(3'd0, 5'd0, 24'h0); bus.dififo_rdempty = 1'b0;
    while (n_dirq - b < 3 && k < 30) begin at_neg(); k++; end
    at_pos(); bus.dififo_rdempty = 1'b1;
    n_vec++; if (di_gap !== 3) begin n_bad++; $display("FAIL b2b_period: got %0d want 3", di_gap); end
    wait_idle();
    n_vec++; if (n_dirq - b !== 3) begin n_bad++; $display("FAIL b2b_pops: got %0d want 3", n_dirq - b); end
  endtask

  task automatic test_enable();
    int b, bb, k;
    b = n_dirq; bb = n_busy; k = 0;
    at_pos();
    bus.dififo_dataq = mk(3'd2, 5'd0, 24'd4); bus.dififo_rdempty = 1'b0;
    while (n_dirq == b && k < 20) begin at_neg(); k++; end
    at_pos(); enable = 1'b0;
    repeat (10) at_neg();
    n_vec++; if (n_dirq - b !== 1) begin n_bad++; $display("FAIL enable_park: got %0d pops want 1", n_dirq - b); end
    n_vec++; if (n_busy - bb !== 6) begin n_bad++; $display("FAIL enable_finish: got %0d busy want 6", n_busy - bb); end
    at_pos(); bus.dififo_rdempty = 1'b1; enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int bw, k;
    logic [4:0] strobes;
    issue(mk(3'd3, 5'd0, 24'h00F0F0));
    wait_idle();
    bw = n_wr; k = 0;
    bus.sfifo_dataq = 24'h777777; bus.sfifo_rdempty = 1'b0;
    issue(mk(3'd1, 5'd20, 24'h0));
    while ((cyc - 1) < di_cyc + 6 && k < 50) begin at_neg(); k++; end
    at_pos(); reset = 1'b1;
    at_neg();
    strobes = {busy, bus.dififo_rdreq, bus.sfifo_rdreq, bus.rfifo_wrreq, bus.dut_reset};
    n_vec++; if (strobes !== 5'b0) begin n_bad++; $display("FAIL rstmid_strobes: got %b want 00000", strobes); end
    n_vec++; if (bus.dut_in !== 24'h0) begin n_bad++; $display("FAIL rstmid_dut_in: got %h want 000000", bus.dut_in); end
    n_vec++; if (bus.rfifo_data !== 24'h0) begin n_bad++; $display("FAIL rstmid_rdata: got %h want 000000", bus.rfifo_data); end
    n_vec++; if (err_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_err: got %b want 0", err_req); end
    bus.sfifo_rdempty = 1'b1;
    at_pos(); reset = 1'b0;
    repeat (30) at_neg();
    n_vec++; if (n_wr - bw !== 0) begin n_bad++; $display("FAIL rstmid_nopush: got %0d want 0", n_wr - bw); end
    n_vec++; if (vec_count !== 16'd0) begin n_bad++; $display("FAIL rstmid_vcnt: got %0d want 0", vec_count); end
    bus.sfifo_dataq = 24'hABCDEF; bus.sfifo_rdempty = 1'b0;
    issue(mk(3'd1, 5'd0, 24'h0));
    wait_wr(bw);
    at_pos(); bus.sfifo_rdempty = 1'b1;
    n_vec++; if (wr_data !== 24'hABCDEF) begin n_bad++; $display("FAIL rstmid_mask: got %h want abcdef", wr_data); end
    wait_idle();
    n_vec++; if (vec_count !== 16'd1) begin n_bad++; $display("FAIL rstmid_vcnt1: got %0d want 1", vec_count); end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_mask();
    test_sfifo_empty();
    test_wrfull();
    test_dutrst_wait_err();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
